// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and sizes.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/onehot_dec3x8.sv
// Combinational 3-bit index to one-hot expansion; all zeros while disabled.
module onehot_dec3x8
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]  idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with one-hot grant and a dead RELEASE cycle
// between owners. Define ARB_TIMEOUT_EN to add the forced-release hold timer.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_badTimeout
    $error("rr_arbiter8: TIMEOUT must be in 2..255");
  end

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] gntId_q, gntId_d;
  logic [ID_W-1:0] lastId_q, lastId_d;

  // Rotate so the search starts just above the last winner, then rotate back.
  logic [ID_W-1:0]    startId;
  logic [2*N_REQ-2:0] reqDup;
  logic [N_REQ-1:0]   reqRot;
  logic [ID_W-1:0]    offset;
  logic [ID_W-1:0]    winner;

  assign startId = lastId_q + 3'd1;
  assign reqDup  = {req[N_REQ-2:0], req};
  assign reqRot  = reqDup[startId +: N_REQ];
  assign winner  = startId + offset;

  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (reqRot[i]) offset = ID_W'(i);
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] holdCnt_q, holdCnt_d;
  logic       timeout_q, timeout_d;
  logic       holdExpired;

  assign holdExpired = (holdCnt_q == 8'(TIMEOUT - 1));
`endif

  logic ownerLeaves;

  always_comb begin
    state_d     = state_q;
    gntId_d     = gntId_q;
    lastId_d    = lastId_q;
    ownerLeaves = done || !req[gntId_q];
`ifdef ARB_TIMEOUT_EN
    holdCnt_d   = holdCnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d  = GRANT;
          gntId_d  = winner;
          lastId_d = winner;
`ifdef ARB_TIMEOUT_EN
          holdCnt_d = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        holdCnt_d = holdCnt_q + 8'd1;
        // A simultaneous done makes this an ordinary release with no pulse.
        if (holdExpired && !done) timeout_d = 1'b1;
        if (ownerLeaves || holdExpired) state_d = RELEASE;
`else
        if (ownerLeaves) state_d = RELEASE;
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gntId_q  <= '0;
      lastId_q <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gntId_q  <= gntId_d;
      lastId_q <= lastId_d;
`ifdef ARB_TIMEOUT_EN
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy   = (state_q == GRANT);
  assign gnt_id = gntId_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

  onehot_dec3x8 u_dec (
    .idx_i    (gntId_q),
    .en_i     (busy),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed literal checks plus random
// traffic compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int  TB_TIMEOUT = 4;
  localparam bit  TIMEOUT_ON = 1'b1;
`else
  localparam int  TB_TIMEOUT = 16;
  localparam bit  TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gntId;
  logic       busy;
  logic       timeoutSig;

  int compared = 0;
  int mismatched = 0;

  rr_arbiter8 #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gntId),
    .busy   (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout (timeoutSig)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign timeoutSig = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 owned, 2 dead cycle after release.
  int mPhase = 0;
  int mOwner = 0;
  int mLast = 7;
  int mHold = 0;
  bit mTimeout = 1'b0;
  bit mValid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mPhase = 0; mOwner = 0; mLast = 7; mHold = 0; mTimeout = 1'b0;
      mValid = 1'b1;
    end else begin
      mTimeout = 1'b0;
      if (mPhase == 0) begin
        if (req != 8'h00) begin
          for (int k = 1; k <= 8; k++) begin
            if (req[(mLast + k) % 8] && mPhase == 0) begin
              mOwner = (mLast + k) % 8;
              mPhase = 1;
            end
          end
          mLast = mOwner;
          mHold = 0;
        end
      end else if (mPhase == 1) begin
        bit expired;
        expired = TIMEOUT_ON && (mHold == TB_TIMEOUT - 1);
        if (done || !req[mOwner] || expired) begin
          mPhase = 2;
          mTimeout = expired && !done;
        end else begin
          mHold = mHold + 1;
        end
      end else begin
        mPhase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      logic [7:0] expGnt;
      expGnt = (mPhase == 1) ? (8'h01 << mOwner) : 8'h00;
      compared++;
      if (gnt !== expGnt || busy !== (mPhase == 1)) begin
        mismatched++;
        $display("[TB] FAIL model_gnt: gnt=%h busy=%b, required gnt=%h busy=%b at %0t",
                 gnt, busy, expGnt, (mPhase == 1), $time);
      end
      if (mPhase == 1) begin
        compared++;
        if (gntId !== 3'(mOwner)) begin
          mismatched++;
          $display("[TB] FAIL model_gnt_id: got %0d, required %0d at %0t", gntId, mOwner, $time);
        end
      end
      compared++;
      if ($countones(gnt) > 1) begin
        mismatched++;
        $display("[TB] FAIL onehot: gnt=%h is multi-hot at %0t", gnt, $time);
      end
      if (TIMEOUT_ON) begin
        compared++;
        if (timeoutSig !== mTimeout) begin
          mismatched++;
          $display("[TB] FAIL model_timeout: got %b, required %b at %0t", timeoutSig, mTimeout, $time);
        end
      end
    end
  end

  // Drive inputs at a falling edge and return at the next falling edge.
  task automatic applyStimulus(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expGnt,
                             input logic expBusy, input int expId);
    compared++;
    if (gnt !== expGnt || busy !== expBusy || (expId >= 0 && gntId !== 3'(expId))) begin
      mismatched++;
      $display("[TB] FAIL %s: gnt=%h busy=%b id=%0d, required gnt=%h busy=%b id=%0d",
               name, gnt, busy, gntId, expGnt, expBusy, expId);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    @(negedge clk);
    doReset();
    checkOutput("reset_state", 8'h00, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("idle_no_req", 8'h00, 1'b0, 0);
    end

    applyStimulus(8'hFF, 1'b0);
    checkOutput("rr_first", 8'h01, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'hFF, 1'b1);
      checkOutput("rr_release", 8'h00, 1'b0, -1);
      applyStimulus(8'hFF, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      r = 8'h01 << ((i + 1) % 8);
      checkOutput("rr_order", r, 1'b1, (i + 1) % 8);
    end

    doReset();
    applyStimulus(8'h24, 1'b0);
    checkOutput("req24_owner2", 8'h04, 1'b1, 2);
    applyStimulus(8'hA4, 1'b0);
    checkOutput("no_preempt", 8'h04, 1'b1, 2);
    applyStimulus(8'hA4, 1'b1);
    checkOutput("done_release", 8'h00, 1'b0, -1);
    applyStimulus(8'hA4, 1'b0);
    applyStimulus(8'hA4, 1'b0);
    checkOutput("next_owner5", 8'h20, 1'b1, 5);
    applyStimulus(8'hA4, 1'b1);
    applyStimulus(8'hA4, 1'b0);
    applyStimulus(8'hA4, 1'b0);
    checkOutput("then_owner7", 8'h80, 1'b1, 7);

    doReset();
    applyStimulus(8'h08, 1'b0);
    checkOutput("owner3", 8'h08, 1'b1, 3);
    applyStimulus(8'h00, 1'b0);
    checkOutput("implicit_release", 8'h00, 1'b0, -1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("done_in_idle", 8'h00, 1'b0, -1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("done_in_idle2", 8'h00, 1'b0, -1);

`ifdef ARB_TIMEOUT_EN
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h01, 1'b0);
      checkOutput("hold_cycles", 8'h01, 1'b1, 0);
    end
    applyStimulus(8'h01, 1'b0);
    checkOutput("forced_release", 8'h00, 1'b0, -1);
    compared++;
    if (timeoutSig !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_pulse: got %b, required 1", timeoutSig);
    end
    applyStimulus(8'h01, 1'b0);
    compared++;
    if (timeoutSig !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_single: got %b, required 0", timeoutSig);
    end
    applyStimulus(8'h01, 1'b0);
    checkOutput("regrant", 8'h01, 1'b1, 0);
`endif

    doReset();
    applyStimulus(8'h10, 1'b0);
    checkOutput("owner4", 8'h10, 1'b1, 4);
    rst = 1'b1;
    applyStimulus(8'hFF, 1'b0);
    checkOutput("reset_midgrant", 8'h00, 1'b0, 0);
    rst = 1'b0;
    applyStimulus(8'hFF, 1'b0);
    checkOutput("prio_after_reset", 8'h01, 1'b1, 0);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      r = 8'($urandom_range(255) & $urandom_range(255));
      if (mPhase == 1 && $urandom_range(7) != 0) r[mOwner] = 1'b1;
      applyStimulus(r, ($urandom_range(5) == 0));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
